dmem_ctrl: RTL and testbench
============================

// Module: dmem_ctrl
// PURPOSE
//  Data-memory responder on the far side of the execution unit's load/store port.
//  Decodes mem_req/addr/wr_en and serves words from an on-chip synchronous SRAM.
//  Sub-word stores are done as read-modify-write; hold_flag_o stalls the pipeline while data is in flight.
//  Byte/half extraction and sign extension stay in the execution unit; this block always returns the full aligned word.
// PARAMETERS
//  ADDR_WIDTH  12            word-address bits (depth = 2**ADDR_WIDTH words, 16 KiB default)
//  BASE_ADDR   32'h1000_0000 byte address of word 0; must be aligned to 4*2**ADDR_WIDTH
//  WAIT_STATES 0             extra SRAM wait cycles per access, 0..7
//  INIT_FILE   ""            $readmemh image for the SRAM; empty = no init
// PORTS
//  clk             in   1   clock
//  rst_n           in   1   asynchronous active-low reset
//  mem_req_i       in   1   access request, held stable while hold_flag_o=1
//  mem_wr_en_i     in   1   1=store, 0=load (store wins if both are intended)
//  mem_rd_addr_i   in   32  load byte address
//  mem_wr_addr_i   in   32  store byte address
//  mem_wr_data_i   in   32  store data, already lane-aligned
//  mem_wr_strb_i   in   4   store byte lanes; bit n -> bits [8n+7:8n]
//  mem_size_i      in   2   00=byte 01=half 10=word (used only with DMEM_ALIGN_CHECK_EN)
//  mem_rd_data_o   out  32  aligned load word; valid while mem_rd_valid_o=1
//  mem_rd_valid_o  out  1   one-cycle load-data-valid pulse
//  hold_flag_o     out  1   pipeline stall request
//  mem_err_o       out  1   one-cycle pulse: out-of-range access (or misaligned, see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE, wait counter=0, mem_rd_data_o=0, mem_rd_valid_o=0, mem_err_o=0. hold_flag_o is forced 0 while rst_n=0.
//    SRAM contents are retained. An RMW aborted before its write edge leaves the word unmodified.
//  - Hit: BASE_ADDR <= addr < BASE_ADDR+4*2**ADDR_WIDTH. Word index = addr[ADDR_WIDTH+1:2]; addr[1:0] is ignored.
//  - States: IDLE, RD_WAIT, RESP, RMW_WAIT, RMW_WR. Requests are sampled only in IDLE.
//    mem_req_i still high in RESP/RMW_WR belongs to the completing access and is never re-accepted.
//  - Load, IDLE+req, hit: issue SRAM read, hold=1, go to RD_WAIT if WAIT_STATES>0, else RESP.
//    RD_WAIT counts WAIT_STATES cycles with hold=1.
//    RESP: mem_rd_data_o=SRAM q (registered, holds until next load), valid=1, hold=0, next state IDLE.
//    Latency: data at cycle 1+WAIT_STATES after acceptance.
//  - Store, strb=4'b1111, hit: SRAM written at the accepting edge, hold=0, stay in IDLE (zero stall).
//  - Store, partial non-zero strb, hit: issue read, hold=1, go to RMW_WAIT (WAIT_STATES cycles) then RMW_WR.
//    RMW_WR: write (q & ~mask) | (wr_data & mask), hold=0, next state IDLE.
//  - Store with strb=0: no SRAM access, no error, hold=0.
//  - Miss: no SRAM access; mem_err_o pulses the cycle after acceptance; hold=0.
//    Load miss returns 0 with mem_rd_valid_o=1 in that cycle.
//  - Ordering: a load issued the cycle after any store/RMW_WR sees the written data (separate cycles, no bypass needed).
//  - hold_flag_o is combinational: (IDLE & req & hit & (load | partial strb)) | RD_WAIT | RMW_WAIT.
// CONFIGURATION
//  DMEM_ALIGN_CHECK_EN defined: half with addr[0]!=0, or word with addr[1:0]!=0, is rejected.
//    Rejected access: no SRAM access, mem_err_o pulse, load returns 0 with valid, hold=0.
//  DMEM_ALIGN_CHECK_EN undefined: mem_size_i is ignored; misaligned accesses use the word index and strobes as given.
// STRUCTURE
//  - dmem_defs.vh: state encodings, SIZE_B/H/W codes, BASE/limit helper macros.
//  - Sub-module dmem_sram: single-port, word-wide, 1-cycle read, no byte enables (this is why RMW exists).
//  - Controller FSM, wait counter and merge logic live in dmem_ctrl.
// TESTING
//  1 Reset with req=1: hold_flag_o=0, rd_data=0. Release, then load 0x1000_0000 -> hold 1 cycle, rd_data=INIT word0, valid pulse.
//  2 Store 0x1000_0008 data 0xDEADBEEF strb 1111 -> no hold. Next-cycle load 0x1000_0008 -> 0xDEADBEEF.
//  3 Store 0x1000_0008 data 0x0000_5500 strb 0010 -> hold 1 cycle (WAIT_STATES=0). Reload -> 0xDEAD55EF.
//  4 WAIT_STATES=3, load -> hold exactly 4 cycles, valid on cycle 4. Assert rst_n mid-RD_WAIT -> IDLE, hold=0.
//  5 Load 0x2000_0000 (miss) -> mem_err_o pulse, rd_data=0, no hold.
//    Store miss -> err pulse, SRAM unchanged (full-memory compare).
//  6 DMEM_ALIGN_CHECK_EN, word load 0x1000_0002 -> err pulse, rd_data=0.
//    Without the macro, the same load returns word 0.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: controller states, access-size codes and the sub-word store merge
// shared by the data-memory controller.
package dmem_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RD_WAIT, S_RESP, S_RMW_WAIT, S_RMW_WR} state_t;
  typedef enum logic [1:0] {SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10} size_t;
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] q, input logic [31:0] d,
                                        input logic [3:0] strb);
    return (q & ~strb_mask(strb)) | (d & strb_mask(strb));
  endfunction
endpackage

// File: rtl/dmem_sram.sv
// dmem_sram: single-port word-wide synchronous SRAM with one-cycle read and no byte
// enables; sub-word writes are handled upstream as read-modify-write.
module dmem_sram #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_q
);
  logic [31:0] r_mem [2**AW];
  logic [31:0] r_q;
  always_ff @(posedge clk)
    if (i_en) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      else r_q <= r_mem[i_addr];
    end
  assign o_q = r_q;
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory responder for the load/store port; full-word stores are
// single-cycle, partial stores are read-modify-write. Define DMEM_ALIGN_CHECK_EN to reject misaligned accesses.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req_i,
  input  logic        mem_wr_en_i,
  input  logic [31:0] mem_rd_addr_i,
  input  logic [31:0] mem_wr_addr_i,
  input  logic [31:0] mem_wr_data_i,
  input  logic [3:0]  mem_wr_strb_i,
  input  logic [1:0]  mem_size_i,
  output logic [31:0] mem_rd_data_o,
  output logic        mem_rd_valid_o,
  output logic        hold_flag_o,
  output logic        mem_err_o
);
  state_t                r_state;
  logic [2:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [31:0]           r_wdata;
  logic [3:0]            r_strb;
  logic [31:0]           r_rd_data;
  logic                  r_rd_valid;
  logic                  r_err;
  logic [31:0]           w_addr;
  logic                  w_hit, w_bad, w_idle_req, w_ok, w_ld, w_full, w_part, w_rej;
  logic                  w_en, w_we;
  logic [ADDR_WIDTH-1:0] w_sidx;
  logic [31:0]           w_sdata, w_q;

  assign w_addr = mem_wr_en_i ? mem_wr_addr_i : mem_rd_addr_i;
  // BASE_ADDR is aligned to the region size, so a hit is a match of the upper bits.
  assign w_hit  = w_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2];
`ifdef DMEM_ALIGN_CHECK_EN
  assign w_bad = (mem_size_i == SIZE_H && w_addr[0]) ||
                 (mem_size_i == SIZE_W && w_addr[1:0] != 2'b00);
`else
  logic w_unused;
  assign w_unused = ^{mem_size_i, w_addr[1:0]};
  assign w_bad    = 1'b0;
`endif
  assign w_idle_req = rst_n && r_state == S_IDLE && mem_req_i;
  assign w_ok       = w_idle_req && w_hit && !w_bad;
  assign w_ld       = w_ok && !mem_wr_en_i;
  assign w_full     = w_ok && mem_wr_en_i && mem_wr_strb_i == 4'hF;
  assign w_part     = w_ok && mem_wr_en_i && mem_wr_strb_i != 4'h0 && mem_wr_strb_i != 4'hF;
  assign w_rej      = w_idle_req && !(w_hit && !w_bad) && !(mem_wr_en_i && mem_wr_strb_i == 4'h0);

  assign hold_flag_o = w_ld || w_part || (rst_n && (r_state == S_RD_WAIT || r_state == S_RMW_WAIT));
  assign w_we    = w_full || (rst_n && r_state == S_RMW_WR);
  assign w_en    = w_we || w_ld || w_part;
  assign w_sidx  = r_state == S_IDLE ? w_addr[ADDR_WIDTH+1:2] : r_idx;
  assign w_sdata = r_state == S_IDLE ? mem_wr_data_i : merge(w_q, r_wdata, r_strb);

  dmem_sram #(.AW(ADDR_WIDTH)) u_sram (
    .clk     (clk),
    .i_en    (w_en),
    .i_we    (w_we),
    .i_addr  (w_sidx),
    .i_wdata (w_sdata),
    .o_q     (w_q)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_idx      <= '0;
      r_wdata    <= 32'd0;
      r_strb     <= 4'd0;
      r_rd_data  <= 32'd0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_err      <= w_rej;
      case (r_state)
        S_IDLE: begin
          r_idx   <= w_addr[ADDR_WIDTH+1:2];
          r_wdata <= mem_wr_data_i;
          r_strb  <= mem_wr_strb_i;
          r_cnt   <= 3'(WAIT_STATES - 1);
          if (w_rej && !mem_wr_en_i) begin
            r_rd_data  <= 32'd0;
            r_rd_valid <= 1'b1;
          end
          if (w_ld) begin
            r_state    <= (WAIT_STATES > 0) ? S_RD_WAIT : S_RESP;
            r_rd_valid <= WAIT_STATES == 0;
          end else if (w_part) r_state <= (WAIT_STATES > 0) ? S_RMW_WAIT : S_RMW_WR;
        end
        S_RD_WAIT:
          if (r_cnt == 3'd0) begin
            r_state    <= S_RESP;
            r_rd_valid <= 1'b1;
          end else r_cnt <= r_cnt - 3'd1;
        S_RESP: begin
          r_rd_data <= w_q;
          r_state   <= S_IDLE;
        end
        S_RMW_WAIT:
          if (r_cnt == 3'd0) r_state <= S_RMW_WR;
          else r_cnt <= r_cnt - 3'd1;
        S_RMW_WR: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end

  // The SRAM word is presented directly in RESP and captured for the following cycles.
  assign mem_rd_data_o  = r_state == S_RESP ? w_q : r_rd_data;
  assign mem_rd_valid_o = r_rd_valid;
  assign mem_err_o      = r_err;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: checks dmem_ctrl with zero and three wait states against a
// transaction-level memory model; honours DMEM_ALIGN_CHECK_EN when defined.
module tb_dmem_ctrl;
  localparam logic [31:0] BASE = 32'h1000_0000;
  logic        clk = 1'b0;
  logic        rst_n [2];
  logic        req [2], we [2];
  logic [31:0] raddr [2], waddr [2], wdata [2];
  logic [3:0]  strb [2];
  logic [1:0]  size [2];
  logic [31:0] rd_data [2];
  logic        rd_valid [2], hold [2], err [2];

  logic [31:0] mem_m [2][4096];
  logic [31:0] last [2];
  logic        pend_v [2], pend_e [2];
  logic        chk_en [2], exp_hold [2], exp_valid [2], exp_err [2];
  logic [31:0] exp_data [2];
  int          n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .mem_req_i(req[0]), .mem_wr_en_i(we[0]),
    .mem_rd_addr_i(raddr[0]), .mem_wr_addr_i(waddr[0]), .mem_wr_data_i(wdata[0]),
    .mem_wr_strb_i(strb[0]), .mem_size_i(size[0]), .mem_rd_data_o(rd_data[0]),
    .mem_rd_valid_o(rd_valid[0]), .hold_flag_o(hold[0]), .mem_err_o(err[0]));

  dmem_ctrl #(.WAIT_STATES(3)) u3 (
    .clk(clk), .rst_n(rst_n[1]), .mem_req_i(req[1]), .mem_wr_en_i(we[1]),
    .mem_rd_addr_i(raddr[1]), .mem_wr_addr_i(waddr[1]), .mem_wr_data_i(wdata[1]),
    .mem_wr_strb_i(strb[1]), .mem_size_i(size[1]), .mem_rd_data_o(rd_data[1]),
    .mem_rd_valid_o(rd_valid[1]), .hold_flag_o(hold[1]), .mem_err_o(err[1]));

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d at %0t: got %h, expected %h", name, k, $time, act, exp);
    end
  endtask

  always @(negedge clk)
    for (int k = 0; k < 2; k++)
      if (chk_en[k]) begin
        check("hold", k, {31'b0, hold[k]}, {31'b0, exp_hold[k]});
        check("valid", k, {31'b0, rd_valid[k]}, {31'b0, exp_valid[k]});
        check("err", k, {31'b0, err[k]}, {31'b0, exp_err[k]});
        check("rd_data", k, rd_data[k], exp_data[k]);
      end

  function automatic logic hit_f(input logic [31:0] a);
    return a >= BASE && a < BASE + 32'd16384;
  endfunction

  function automatic logic bad_f(input logic [31:0] a, input logic [1:0] z);
    logic en = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    en = 1'b1;
`endif
    return en && ((z == 2'b01 && a[0]) || (z == 2'b10 && a[1:0] != 2'b00));
  endfunction

  task automatic drive(input int k, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s, input logic [1:0] z);
    req[k] = r; we[k] = w; wdata[k] = d; strb[k] = s; size[k] = z;
    raddr[k] = w ? 32'hFFFF_FFFC : a;
    waddr[k] = w ? a : BASE + 32'd4;
  endtask

  task automatic cyc(input int k, input logic h, input logic v, input logic e, input logic [31:0] d);
    exp_hold[k] = h; exp_valid[k] = v; exp_err[k] = e; exp_data[k] = d; chk_en[k] = 1'b1;
    @(negedge clk);
    #1 chk_en[k] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k, input int n);
    drive(k, 1'b0, 1'b0, BASE, 32'd0, 4'd0, 2'b10);
    repeat (n) begin
      cyc(k, 1'b0, pend_v[k], pend_e[k], last[k]);
      pend_v[k] = 1'b0; pend_e[k] = 1'b0;
    end
  endtask

  task automatic access(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] z);
    int   ws  = k ? 3 : 0;
    int   idx = int'((a - BASE) >> 2);
    logic pv  = pend_v[k];
    logic pe  = pend_e[k];
    logic ok  = hit_f(a) && !bad_f(a, z);
    drive(k, 1'b1, w, a, d, s, z);
    pend_v[k] = 1'b0; pend_e[k] = 1'b0;
    if (w && s == 4'h0) cyc(k, 1'b0, pv, pe, last[k]);
    else if (!ok) begin
      cyc(k, 1'b0, pv, pe, last[k]);
      pend_e[k] = 1'b1; pend_v[k] = !w;
      if (!w) last[k] = 32'd0;
    end else if (!w) begin
      cyc(k, 1'b1, pv, pe, last[k]);
      repeat (ws) cyc(k, 1'b1, 1'b0, 1'b0, last[k]);
      last[k] = mem_m[k][idx];
      cyc(k, 1'b0, 1'b1, 1'b0, last[k]);
    end else if (s == 4'hF) begin
      cyc(k, 1'b0, pv, pe, last[k]);
      mem_m[k][idx] = d;
    end else begin
      cyc(k, 1'b1, pv, pe, last[k]);
      repeat (ws) cyc(k, 1'b1, 1'b0, 1'b0, last[k]);
      cyc(k, 1'b0, 1'b0, 1'b0, last[k]);
      for (int b = 0; b < 4; b++) if (s[b]) mem_m[k][idx][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic do_reset(input int k, input logic r);
    drive(k, r, 1'b0, BASE, 32'd0, 4'd0, 2'b10);
    rst_n[k] = 1'b0;
    last[k] = 32'd0; pend_v[k] = 1'b0; pend_e[k] = 1'b0;
    cyc(k, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc(k, 1'b0, 1'b0, 1'b0, 32'd0);
    drive(k, 1'b0, 1'b0, BASE, 32'd0, 4'd0, 2'b10);
    rst_n[k] = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; chk_en[k] = 1'b0; last[k] = 32'd0; pend_v[k] = 1'b0; pend_e[k] = 1'b0;
      drive(k, 1'b0, 1'b0, BASE, 32'd0, 4'd0, 2'b10);
    end
    @(posedge clk);
    #1;
    do_reset(0, 1'b0);
    do_reset(1, 1'b0);
    for (int i = 0; i < 4096; i++) access(0, 1'b1, BASE + 32'(4 * i), 32'hC0DE_0000 | 32'(i), 4'hF, 2'b10);
    idle(0, 1);
    // Reset with a pending request; SRAM contents must survive.
    do_reset(0, 1'b1);
    check("t1_rst_data", 0, rd_data[0], 32'h0);
    access(0, 1'b0, BASE, 32'd0, 4'd0, 2'b10);
    check("t1_word0", 0, rd_data[0], 32'hC0DE_0000);
    check("t1_model", 0, last[0], 32'hC0DE_0000);
    idle(0, 2);
    access(0, 1'b1, BASE + 32'd8, 32'hDEAD_BEEF, 4'hF, 2'b10);
    access(0, 1'b0, BASE + 32'd8, 32'd0, 4'd0, 2'b10);
    check("t2_full", 0, rd_data[0], 32'hDEAD_BEEF);
    access(0, 1'b1, BASE + 32'd8, 32'h0000_5500, 4'b0010, 2'b10);
    access(0, 1'b0, BASE + 32'd8, 32'd0, 4'd0, 2'b10);
    check("t3_rmw", 0, rd_data[0], 32'hDEAD_55EF);
    access(0, 1'b1, BASE + 32'd8, 32'h1111_1111, 4'b0000, 2'b10);
    access(0, 1'b1, BASE + 32'd12, 32'h7700_0066, 4'b1001, 2'b10);
    access(0, 1'b0, BASE + 32'd8, 32'd0, 4'd0, 2'b10);
    check("t3_strb0", 0, rd_data[0], 32'hDEAD_55EF);
    access(0, 1'b0, BASE + 32'd12, 32'd0, 4'd0, 2'b10);
    check("t3_rmw2", 0, rd_data[0], 32'h77DE_0066);
    access(0, 1'b0, BASE + 32'd16380, 32'd0, 4'd0, 2'b10);
    idle(0, 1);
    access(1, 1'b1, BASE + 32'd16, 32'h1234_5678, 4'hF, 2'b10);
    access(1, 1'b0, BASE + 32'd16, 32'd0, 4'd0, 2'b10);
    check("t4_ws3", 1, rd_data[1], 32'h1234_5678);
    access(1, 1'b1, BASE + 32'd16, 32'hAB00_0000, 4'b1000, 2'b10);
    access(1, 1'b0, BASE + 32'd16, 32'd0, 4'd0, 2'b10);
    check("t4_ws3_rmw", 1, rd_data[1], 32'hAB34_5678);
    idle(1, 1);
    // Reset in the middle of RD_WAIT, then in the middle of RMW_WAIT.
    drive(1, 1'b1, 1'b0, BASE + 32'd16, 32'd0, 4'd0, 2'b10);
    cyc(1, 1'b1, 1'b0, 1'b0, last[1]);
    cyc(1, 1'b1, 1'b0, 1'b0, last[1]);
    rst_n[1] = 1'b0; last[1] = 32'd0;
    cyc(1, 1'b0, 1'b0, 1'b0, 32'd0);
    drive(1, 1'b0, 1'b0, BASE, 32'd0, 4'd0, 2'b10);
    rst_n[1] = 1'b1;
    idle(1, 4);
    drive(1, 1'b1, 1'b1, BASE + 32'd16, 32'h0000_00CD, 4'b0001, 2'b10);
    cyc(1, 1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1, 1'b1, 1'b0, 1'b0, 32'd0);
    rst_n[1] = 1'b0;
    cyc(1, 1'b0, 1'b0, 1'b0, 32'd0);
    drive(1, 1'b0, 1'b0, BASE, 32'd0, 4'd0, 2'b10);
    rst_n[1] = 1'b1;
    idle(1, 2);
    access(1, 1'b0, BASE + 32'd16, 32'd0, 4'd0, 2'b10);
    check("t4_rmw_abort", 1, rd_data[1], 32'hAB34_5678);
    idle(1, 1);
    access(0, 1'b0, 32'h2000_0000, 32'd0, 4'd0, 2'b10);
    idle(0, 1);
    check("t5_miss_data", 0, rd_data[0], 32'h0);
    access(0, 1'b0, BASE + 32'd20, 32'd0, 4'd0, 2'b10);
    access(0, 1'b0, BASE - 32'd4, 32'd0, 4'd0, 2'b10);
    access(0, 1'b0, BASE + 32'd16384, 32'd0, 4'd0, 2'b10);
    access(0, 1'b1, 32'h2000_0000, 32'hFFFF_FFFF, 4'hF, 2'b10);
    access(0, 1'b1, BASE + 32'd16384, 32'hFFFF_FFFF, 4'hF, 2'b10);
    access(0, 1'b1, BASE - 32'd4, 32'hFFFF_FFFF, 4'b0110, 2'b10);
    idle(0, 2);
    for (int i = 0; i < 4096; i++) check("t5_mem", 0, u0.u_sram.r_mem[i], mem_m[0][i]);
    access(0, 1'b0, BASE + 32'd2, 32'd0, 4'd0, 2'b10);
    idle(0, 1);
`ifdef DMEM_ALIGN_CHECK_EN
    check("t6_misalign", 0, rd_data[0], 32'h0);
`else
    check("t6_misalign", 0, rd_data[0], 32'hC0DE_0000);
`endif
    access(0, 1'b0, BASE + 32'd5, 32'd0, 4'd0, 2'b01);
    access(0, 1'b0, BASE + 32'd6, 32'd0, 4'd0, 2'b01);
    access(0, 1'b1, BASE + 32'd4, 32'h0000_00AA, 4'b0001, 2'b00);
    access(0, 1'b1, BASE + 32'd1, 32'h0000_BB00, 4'b0010, 2'b10);
    access(0, 1'b0, BASE, 32'd0, 4'd0, 2'b10);
    access(0, 1'b0, BASE + 32'd4, 32'd0, 4'd0, 2'b10);
    check("t6_byte", 0, rd_data[0], 32'hC0DE_00AA);
    idle(0, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
